// File: rtl/audio_fifo_pkg.sv
// Register map, bit positions and frame type shared by the audio sample FIFO.
package audio_fifo_pkg;

  localparam logic [3:0] AF_REG_DATA_L = 4'h0;
  localparam logic [3:0] AF_REG_DATA_R = 4'h4;
  localparam logic [3:0] AF_REG_STATUS = 4'h8;
  localparam logic [3:0] AF_REG_CTRL   = 4'hC;

  localparam int AF_ST_EMPTY   = 0;
  localparam int AF_ST_FULL    = 1;
  localparam int AF_ST_OVF     = 2;
  localparam int AF_ST_LVL_LSB = 16;

  localparam int AF_CTRL_EN      = 0;
  localparam int AF_CTRL_FLUSH   = 1;
  localparam int AF_CTRL_THR_LSB = 16;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
  } audio_frame_t;

endpackage

// File: rtl/audio_fifo_mem.sv
// DEPTH x 48-bit frame storage with wrapping pointers and a level counter; no bus logic.
module audio_fifo_mem
  import audio_fifo_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  audio_frame_t     i_wdata,
  output audio_frame_t     o_rdata,
  output logic [LVL_W-1:0] o_level,
  output logic             o_empty,
  output logic             o_full
);

  audio_frame_t     r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LVL_W-1:0] r_level;

  always_ff @(posedge clk_i) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes them wrap for free.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_level = r_level;
  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LVL_W'(DEPTH));

endmodule

// File: rtl/audio_sample_fifo.sv
// Wishbone-fed stereo frame FIFO draining into the I2S master frame port.
// Optional level interrupt and CTRL.THRESH field: define AUDIO_FIFO_IRQ_EN.
module audio_sample_fifo
  import audio_fifo_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  output logic [23:0] frame_l_o,
  output logic [23:0] frame_r_o,
  output logic        write_frame_o,
  input  logic        i2s_full_i
`ifdef AUDIO_FIFO_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  logic [3:0]       w_sel;
  logic             w_wr, w_rd;
  logic             w_wr_datal, w_wr_datar, w_wr_status, w_wr_ctrl;
  logic             w_flush, w_pop, w_push, w_drop;
  logic             w_empty, w_full;
  logic [LVL_W-1:0] w_level;
  audio_frame_t     w_head, w_wframe;
  logic [31:0]      w_rdata;
  logic             w_unused;

  logic             r_ack, r_wf, r_en, r_ovf;
  logic [31:0]      r_dat;
  logic [23:0]      r_hold, r_frame_l, r_frame_r;
`ifdef AUDIO_FIFO_IRQ_EN
  logic [7:0]       r_thresh;
  logic             r_irq;
`endif

  assign w_sel       = {wb_adr_i[3:2], 2'b00};
  assign w_wr        = wb_stb_i && wb_we_i;
  assign w_rd        = wb_stb_i && !wb_we_i;
  assign w_wr_datal  = w_wr && (w_sel == AF_REG_DATA_L);
  assign w_wr_datar  = w_wr && (w_sel == AF_REG_DATA_R);
  assign w_wr_status = w_wr && (w_sel == AF_REG_STATUS);
  assign w_wr_ctrl   = w_wr && (w_sel == AF_REG_CTRL);
  assign w_flush     = w_wr_ctrl && wb_dat_i[AF_CTRL_FLUSH];

  // r_wf blocks back-to-back pops so i2s_full_i has a cycle to react; flush wins over a due pop.
  assign w_pop  = r_en && !w_empty && !i2s_full_i && !r_wf && !w_flush;
  assign w_push = w_wr_datar && (!w_full || w_pop);
  assign w_drop = w_wr_datar && w_full && !w_pop;

  assign w_wframe = '{l: r_hold, r: wb_dat_i[23:0]};
  assign w_unused = ^{wb_adr_i[1:0], wb_dat_i[31:24]};

  audio_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (w_wframe),
    .o_rdata (w_head),
    .o_level (w_level),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      AF_REG_DATA_L: w_rdata[23:0] = r_hold;
      AF_REG_STATUS: begin
        w_rdata[AF_ST_EMPTY] = w_empty;
        w_rdata[AF_ST_FULL]  = w_full;
        w_rdata[AF_ST_OVF]   = r_ovf;
        w_rdata[31:AF_ST_LVL_LSB] = 16'(w_level);
      end
      AF_REG_CTRL: begin
        w_rdata[AF_CTRL_EN] = r_en;
`ifdef AUDIO_FIFO_IRQ_EN
        w_rdata[AF_CTRL_THR_LSB +: 8] = r_thresh;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_hold    <= '0;
      r_en      <= 1'b0;
      r_ovf     <= 1'b0;
      r_wf      <= 1'b0;
      r_frame_l <= '0;
      r_frame_r <= '0;
    end else begin
      r_ack <= wb_stb_i;
      r_dat <= w_rd ? w_rdata : '0;
      r_wf  <= w_pop;
      if (w_wr_datal) r_hold <= wb_dat_i[23:0];
      if (w_wr_ctrl)  r_en   <= wb_dat_i[AF_CTRL_EN];
      if (w_drop)
        r_ovf <= 1'b1;
      else if (w_wr_status && wb_dat_i[AF_ST_OVF])
        r_ovf <= 1'b0;
      if (w_pop) begin
        r_frame_l <= w_head.l;
        r_frame_r <= w_head.r;
      end
    end
  end

`ifdef AUDIO_FIFO_IRQ_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_thresh <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_thresh <= wb_dat_i[AF_CTRL_THR_LSB +: 8];
      r_irq <= r_en && (32'(w_level) <= 32'(r_thresh));
    end
  end
  assign irq_o = r_irq;
`endif

  assign wb_ack_o      = r_ack;
  assign wb_dat_o      = r_dat;
  assign wb_stall_o    = 1'b0;
  assign frame_l_o     = r_frame_l;
  assign frame_r_o     = r_frame_r;
  assign write_frame_o = r_wf;

endmodule
